tdc_glitch_monitor: RTL and testbench

Parametrised successor to the delay-line popcount stage in the voltage glitch detectors.
- Registers a WIDTH-bit thermometer/delay-line snapshot every cycle and produces a pipelined popcount over all WIDTH bits.
- Calibrates a baseline count, then flags samples whose deviation from the baseline exceeds a programmable threshold.
- Keeps a sticky alarm, a saturating event counter and min/max statistics.
- Sits between the sensor delay line and the injection-campaign logging logic.

---
 rtl/tdc_glitch_monitor.sv | 187 ++++++++++++++++++
 tb/tb_tdc_glitch_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tdc_glitch_monitor.sv
// tdc_glitch_monitor
// Registers a delay-line snapshot, popcounts it, calibrates a baseline from
// 2^CAL_LOG2 samples and then flags samples that stray from that baseline by
// more than a programmable threshold. Keeps a sticky alarm, a saturating event
// counter and min/max statistics of the counts seen while monitoring.
module tdc_glitch_monitor #(
  parameter int WIDTH    = 90,
  parameter int CNT_W    = $clog2(WIDTH+1),
  parameter int CAL_LOG2 = 4,
  parameter int EVT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] thresh,
  input  logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic [CNT_W-1:0] baseline,
  output logic             cal_done,
  output logic             glitch,
  output logic             alarm,
  output logic [EVT_W-1:0] event_cnt,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAL  = 2'd1;
  localparam logic [1:0] S_MON  = 2'd2;

  localparam int ACC_W  = CNT_W + CAL_LOG2;
  // one spare bit so CAL_LOG2 = 0 still yields a legal counter
  localparam int SCNT_W = CAL_LOG2 + 1;
  localparam logic [SCNT_W-1:0] CAL_LAST = SCNT_W'((1 << CAL_LOG2) - 1);

  // pipeline
  logic [WIDTH-1:0]  r_q;
  logic              r_v1;
  logic [CNT_W-1:0]  r_count;
  logic              r_cnt_vld;
  logic [CNT_W-1:0]  w_pop;

  // control / calibration
  logic [1:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [SCNT_W-1:0] r_scnt;
  logic [CNT_W-1:0]  r_base;
  logic              r_cal_done;
  logic              r_glitch;

  // statistics
  logic              r_alarm;
  logic [EVT_W-1:0]  r_evt;
  logic [CNT_W-1:0]  r_min;
  logic [CNT_W-1:0]  r_max;

  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_dev;
  logic              w_cal_fin;
  logic              w_mon_smp;
  logic [CNT_W-1:0]  w_min_b;
  logic [CNT_W-1:0]  w_max_b;

  // Stage 1: capture the raw taps and the enable alongside them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_q  <= q;
      r_v1 <= en;
    end
  end

  // Popcount over every tap, top bit included
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pop = w_pop + {{(CNT_W-1){1'b0}}, r_q[i]};
  end

  // Stage 2: register the count; dropping en discards the sample in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_cnt_vld <= 1'b0;
    end else begin
      r_cnt_vld <= r_v1 & en;
      if (r_v1 && en)
        r_count <= w_pop;
    end
  end

  assign w_acc_next = r_acc + ACC_W'(r_count);
  // absolute difference without wrap
  assign w_dev      = (r_count >= r_base) ? (r_count - r_base) : (r_base - r_count);
  assign w_cal_fin  = en && (r_state == S_CAL) && r_cnt_vld && (r_scnt == CAL_LAST);
  assign w_mon_smp  = en && (r_state == S_MON) && r_cnt_vld;

  // IDLE/CAL/MON sequencing, baseline averaging and glitch detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_scnt     <= '0;
      r_base     <= '0;
      r_cal_done <= 1'b0;
      r_glitch   <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      if (!en) begin
        r_state    <= S_IDLE;
        r_cal_done <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_CAL;
            r_acc      <= '0;
            r_scnt     <= '0;
            r_cal_done <= 1'b0;
          end
          S_CAL: begin
            if (r_cnt_vld) begin
              r_acc  <= w_acc_next;
              r_scnt <= r_scnt + SCNT_W'(1);
              if (r_scnt == CAL_LAST) begin
                r_state    <= S_MON;
                r_base     <= CNT_W'(w_acc_next >> CAL_LOG2);
                r_cal_done <= 1'b1;
              end
            end
          end
          S_MON: begin
            if (r_cnt_vld)
              r_glitch <= (w_dev > thresh);
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // clear restores the reset values, then a same-cycle sample lands on top
  assign w_min_b = clear ? {CNT_W{1'b1}} : r_min;
  assign w_max_b = clear ? {CNT_W{1'b0}} : r_max;

  // min/max tracking while monitoring, re-seeded when calibration finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_cal_fin) begin
      r_min <= '1;
      r_max <= '0;
    end else begin
      r_min <= (w_mon_smp && (r_count < w_min_b)) ? r_count : w_min_b;
      r_max <= (w_mon_smp && (r_count > w_max_b)) ? r_count : w_max_b;
    end
  end

  // sticky alarm and saturating event count; a glitch beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
      r_evt   <= '0;
    end else begin
      r_alarm <= r_glitch | (r_alarm & ~clear);
      if (clear)
        r_evt <= {{(EVT_W-1){1'b0}}, r_glitch};
      else if (r_glitch && (r_evt != {EVT_W{1'b1}}))
        r_evt <= r_evt + EVT_W'(1);
    end
  end

  assign count       = r_count;
  assign count_valid = r_cnt_vld;
  assign baseline    = r_base;
  assign cal_done    = r_cal_done;
  assign glitch      = r_glitch;
  assign alarm       = r_alarm;
  assign event_cnt   = r_evt;
  assign min_cnt     = r_min;
  assign max_cnt     = r_max;

endmodule

// File: tb/tb_tdc_glitch_monitor.sv
// Scoreboard bench for tdc_glitch_monitor: every driven sample pushes its
// expected popcount and arrival cycle; a small reference model of the
// calibration/monitor behaviour predicts the glitch pulse for each sample.
module tb_tdc_glitch_monitor;
  localparam int W  = 90;
  localparam int CW = 7;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] thresh = 7'd3;
  logic [W-1:0]  q = '0;
  logic [CW-1:0] count, baseline, min_cnt, max_cnt;
  logic          count_valid, cal_done, glitch, alarm;
  logic [EW-1:0] event_cnt;

  tdc_glitch_monitor #(.WIDTH(W), .CNT_W(CW), .CAL_LOG2(2), .EVT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .thresh(thresh), .q(q),
    .count(count), .count_valid(count_valid), .baseline(baseline),
    .cal_done(cal_done), .glitch(glitch), .alarm(alarm), .event_cnt(event_cnt),
    .min_cnt(min_cnt), .max_cnt(max_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int due; } sb_t;
  sb_t sb[$];

  int checks = 0, failures = 0, tickno = 0;
  // model: md 0=IDLE 1=CAL 2=MON
  int md = 0, n = 0, acc = 0, mbase = 0, pc = 0;
  bit pend = 0, exp_g = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_count_valid", 32'(count_valid), 0);
    chk("rst_baseline", 32'(baseline), 0);
    chk("rst_cal_done", 32'(cal_done), 0);
    chk("rst_glitch", 32'(glitch), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_event_cnt", 32'(event_cnt), 0);
    chk("rst_min_cnt", 32'(min_cnt), 127);
    chk("rst_max_cnt", 32'(max_cnt), 0);
  endtask

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] ones;
    ones = '1;
    return (k == 0) ? '0 : (ones >> (W - k));
  endfunction

  // drive one sample, advance one clock, then score what came out
  task automatic step(input logic [W-1:0] qv, input logic e, input logic c);
    sb_t ent;
    int d;
    q = qv; en = e; clear = c;
    if (!e) begin
      sb.delete(); pend = 0; exp_g = 0; md = 0;
    end else begin
      exp_g = 0;
      if (md == 0) begin
        md = 1; n = 0; acc = 0;
      end else if (pend) begin
        if (md == 1) begin
          acc += pc; n++;
          if (n == 4) begin md = 2; mbase = acc >> 2; end
        end else begin
          d = (pc > mbase) ? pc - mbase : mbase - pc;
          exp_g = (d > int'(thresh));
        end
      end
      pend = 0;
      ent.c = $countones(qv); ent.due = tickno + 2;
      sb.push_back(ent);
    end
    @(posedge clk); #1;
    tickno++;
    chk("glitch", 32'(glitch), 32'(exp_g));
    if (count_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(count_valid), 0);
      else begin
        ent = sb.pop_front();
        chk("count", 32'(count), ent.c);
        chk("latency", tickno, ent.due);
        pend = 1; pc = ent.c;
      end
    end else if (sb.size() != 0 && sb[0].due <= tickno) begin
      chk("missing_valid", 32'(count_valid), 1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] b89;
    b89 = '0; b89[W-1] = 1'b1;

    #2 rst_n = 1'b0;
    #10 chk_reset();
    @(negedge clk) rst_n = 1'b1;

    // popcount extremes and the top tap; en drop aborts calibration
    step(mk(W), 1, 0);
    chk("t1_no_valid_t1", 32'(count_valid), 0);
    step('0, 1, 0);
    step(b89, 1, 0);
    step(b89, 1, 0);
    step(b89, 1, 0);
    step('0, 0, 0);
    step('0, 0, 0);
    chk("count_hold", 32'(count), 1);
    chk("cal_aborted", 32'(cal_done), 0);
    chk("baseline_kept", 32'(baseline), 0);

    // calibration 40..43 -> baseline 41
    step(mk(40), 1, 0);
    step(mk(41), 1, 0);
    step(mk(42), 1, 0);
    step(mk(43), 1, 0);
    step(mk(41), 1, 0);
    chk("cal_not_yet", 32'(cal_done), 0);
    step(mk(41), 1, 0);
    chk("cal_done", 32'(cal_done), 1);
    chk("baseline", 32'(baseline), 41);
    chk("cal_min", 32'(min_cnt), 127);
    chk("cal_max", 32'(max_cnt), 0);

    // thresh 3 around baseline 41
    step(mk(44), 1, 0);
    step(mk(45), 1, 0);
    step(mk(37), 1, 0);
    for (int i = 0; i < 5; i++) step(mk(41), 1, 0);
    chk("t3_alarm", 32'(alarm), 1);
    chk("t3_event", 32'(event_cnt), 2);
    chk("t3_min", 32'(min_cnt), 37);
    chk("t3_max", 32'(max_cnt), 45);

    // event counter saturation, then clear with a sample on top
    for (int i = 0; i < 20; i++) step(mk(60), 1, 0);
    for (int i = 0; i < 5; i++) step(mk(41), 1, 0);
    chk("sat_event", 32'(event_cnt), 15);
    chk("sat_max", 32'(max_cnt), 60);
    step(mk(41), 1, 1);
    chk("clr_event", 32'(event_cnt), 0);
    chk("clr_alarm", 32'(alarm), 0);
    chk("clr_min", 32'(min_cnt), 41);
    chk("clr_max", 32'(max_cnt), 41);

    // clear coinciding with the glitch pulse
    step(mk(50), 1, 0);
    step(mk(41), 1, 0);
    step(mk(41), 1, 0);
    step(mk(41), 1, 1);
    chk("coinc_alarm", 32'(alarm), 1);
    chk("coinc_event", 32'(event_cnt), 1);
    step(mk(41), 1, 0);

    // async reset pulse mid-monitoring, then recalibration
    #3 rst_n = 1'b0;
    #1 chk_reset();
    rst_n = 1'b1;
    sb.delete(); pend = 0; exp_g = 0; md = 0;
    step(mk(30), 1, 0);
    chk("post_rst_no_valid", 32'(count_valid), 0);
    step(mk(30), 1, 0);
    step(mk(30), 1, 0);
    step(mk(30), 1, 0);
    step(mk(30), 1, 0);
    chk("recal_not_yet", 32'(cal_done), 0);
    step(mk(30), 1, 0);
    chk("recal_done", 32'(cal_done), 1);
    chk("recal_baseline", 32'(baseline), 30);

    // threshold boundaries: all ones never fires, zero fires on any deviation
    thresh = 7'h7f;
    step(mk(90), 1, 0);
    for (int i = 0; i < 3; i++) step(mk(30), 1, 0);
    thresh = 7'd0;
    step(mk(31), 1, 0);
    for (int i = 0; i < 4; i++) step(mk(30), 1, 0);
    chk("bnd_event", 32'(event_cnt), 1);
    chk("bnd_max", 32'(max_cnt), 90);
    chk("bnd_min", 32'(min_cnt), 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
